housekeeping_spi_sync: RTL and testbench



---
 rtl/housekeeping_spi_sync.sv | 190 +++++++++++++++++++
 tb/tb_housekeeping_spi_sync.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/housekeeping_spi_sync.sv
// Housekeeping SPI slave, fully in the wb_clk_i domain: the SPI pins are oversampled
// and the register file sees single-cycle rdstb/wrstb strobes.
module housekeeping_spi_sync #(
  parameter int ADDR_WIDTH  = 8,
  parameter int RD_LATENCY  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int PASSTHRU_EN = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rstn_i,
  input  logic                  SCK,
  input  logic                  SDI,
  input  logic                  CSB,
  output logic                  SDO,
  output logic                  sdoenb,
  input  logic [7:0]            idata,
  output logic [7:0]            odata,
  output logic [ADDR_WIDTH-1:0] oaddr,
  output logic                  rdstb,
  output logic                  wrstb,
  output logic                  pass_thru_mgmt,
  output logic                  pass_thru_user,
  output logic                  busy,
  output logic                  xfer_err
);

  localparam logic [1:0] ST_COMMAND = 2'd0;
  localparam logic [1:0] ST_ADDRESS = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_PASS    = 2'd3;

  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam int ACW    = (ABYTES > 1) ? $clog2(ABYTES) : 1;

  logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync;
  logic                   sck_d, csb_d;
  logic                   sck_s, csb_s, sdi_s;
  logic                   sck_rise, sck_fall, csb_rise;

  logic [1:0]            state;
  logic [2:0]            bitcnt;
  logic [ACW-1:0]        abyte;
  logic [6:0]            sr;
  logic [7:0]            byte_in;
  logic [ADDR_WIDTH-2:0] ashift;
  logic                  wr_mode, rd_mode;
  logic [2:0]            nbytes, bytes_done;
  logic [7:0]            ldata;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  inc_pend, cont_pend;
  logic                  last_bit;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d & ~csb_s;
  assign sck_fall = ~sck_s & sck_d & ~csb_s;
  assign csb_rise = csb_s & ~csb_d;
  assign byte_in  = {sr, sdi_s};
  assign last_bit = (bitcnt == 3'd7);
  assign SDO      = ldata[7];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      sck_sync       <= '0;
      csb_sync       <= '1;
      sdi_sync       <= '0;
      sck_d          <= 1'b0;
      csb_d          <= 1'b1;
      state          <= ST_COMMAND;
      bitcnt         <= '0;
      abyte          <= '0;
      sr             <= '0;
      ashift         <= '0;
      wr_mode        <= 1'b0;
      rd_mode        <= 1'b0;
      nbytes         <= '0;
      bytes_done     <= '0;
      ldata          <= '0;
      rd_pipe        <= '0;
      inc_pend       <= 1'b0;
      cont_pend      <= 1'b0;
      sdoenb         <= 1'b1;
      odata          <= '0;
      oaddr          <= '0;
      rdstb          <= 1'b0;
      wrstb          <= 1'b0;
      pass_thru_mgmt <= 1'b0;
      pass_thru_user <= 1'b0;
      busy           <= 1'b0;
      xfer_err       <= 1'b0;
    end else begin
      sck_sync <= SYNC_STAGES'({sck_sync, SCK});
      csb_sync <= SYNC_STAGES'({csb_sync, CSB});
      sdi_sync <= SYNC_STAGES'({sdi_sync, SDI});
      sck_d    <= sck_s;
      csb_d    <= csb_s;
      busy     <= ~csb_s;
      rdstb    <= 1'b0;
      wrstb    <= 1'b0;
      xfer_err <= 1'b0;
      inc_pend <= 1'b0;
      rd_pipe  <= RD_LATENCY'({rd_pipe, rdstb});

      // The fall right after a byte's last rise (bitcnt==0) must not shift,
      // so the freshly loaded MSB is still on SDO for the next rise.
      if (rd_pipe[RD_LATENCY-1]) begin
        ldata  <= idata;
        sdoenb <= 1'b0;
      end else if (sck_fall && bitcnt != 3'd0) begin
        ldata <= {ldata[6:0], 1'b0};
      end

      if (inc_pend) begin
        oaddr <= oaddr + 1'b1;
        rdstb <= rd_mode & cont_pend;
      end

      if (csb_rise) begin
        xfer_err       <= (bitcnt != 3'd0) || (state == ST_ADDRESS);
        state          <= ST_COMMAND;
        bitcnt         <= '0;
        abyte          <= '0;
        bytes_done     <= '0;
        sdoenb         <= 1'b1;
        pass_thru_mgmt <= 1'b0;
        pass_thru_user <= 1'b0;
        ldata          <= '0;
        rd_pipe        <= '0;
        rdstb          <= 1'b0;
      end else if (sck_rise) begin
        bitcnt <= bitcnt + 3'd1;
        sr     <= byte_in[6:0];
        case (state)
          ST_COMMAND: begin
            if (last_bit) begin
              wr_mode    <= byte_in[7];
              rd_mode    <= byte_in[6];
              nbytes     <= byte_in[5:3];
              bytes_done <= '0;
              abyte      <= '0;
              if (PASSTHRU_EN != 0 && byte_in[2]) begin
                state          <= ST_PASS;
                pass_thru_mgmt <= 1'b1;
                sdoenb         <= 1'b0;
              end else if (PASSTHRU_EN != 0 && byte_in[1]) begin
                state          <= ST_PASS;
                pass_thru_user <= 1'b1;
                sdoenb         <= 1'b0;
              end else begin
                state <= ST_ADDRESS;
              end
            end
          end
          ST_ADDRESS: begin
            ashift <= {ashift[ADDR_WIDTH-3:0], sdi_s};
            if (last_bit) begin
              if (abyte == ACW'(ABYTES - 1)) begin
                oaddr <= {ashift, sdi_s};
                rdstb <= rd_mode;
                state <= ST_DATA;
                abyte <= '0;
              end else begin
                abyte <= abyte + 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (last_bit) begin
              odata    <= byte_in;
              wrstb    <= wr_mode;
              inc_pend <= 1'b1;
              if (nbytes != 3'd0 && (bytes_done + 3'd1) == nbytes) begin
                state      <= ST_COMMAND;
                sdoenb     <= 1'b1;
                cont_pend  <= 1'b0;
                bytes_done <= '0;
              end else begin
                cont_pend  <= 1'b1;
                bytes_done <= bytes_done + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// Bench for housekeeping_spi_sync: two instances (8-bit addr / latency 1 / pass-through on,
// 16-bit addr / latency 2 / pass-through off) driven by a bit-banged SPI master.
module tb_housekeeping_spi_sync;
  localparam int H = 10;

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, sck, sdi, csb8, csb16;

  logic       sdo8, en8, rd8, wr8, pm8, pu8, busy8, err8;
  logic [7:0] odata8, oaddr8, idata8;
  logic       sdo16, en16, rd16, wr16, pm16, pu16, busy16, err16;
  logic [7:0] odata16, idata16;
  logic [15:0] oaddr16;

  always #5 clk = ~clk;

  housekeeping_spi_sync #(.ADDR_WIDTH(8), .RD_LATENCY(1), .SYNC_STAGES(2), .PASSTHRU_EN(1)) dut8 (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .SCK(sck), .SDI(sdi), .CSB(csb8),
    .SDO(sdo8), .sdoenb(en8), .idata(idata8), .odata(odata8), .oaddr(oaddr8),
    .rdstb(rd8), .wrstb(wr8), .pass_thru_mgmt(pm8), .pass_thru_user(pu8),
    .busy(busy8), .xfer_err(err8));

  housekeeping_spi_sync #(.ADDR_WIDTH(16), .RD_LATENCY(2), .SYNC_STAGES(3), .PASSTHRU_EN(0)) dut16 (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .SCK(sck), .SDI(sdi), .CSB(csb16),
    .SDO(sdo16), .sdoenb(en16), .idata(idata16), .odata(odata16), .oaddr(oaddr16),
    .rdstb(rd16), .wrstb(wr16), .pass_thru_mgmt(pm16), .pass_thru_user(pu16),
    .busy(busy16), .xfer_err(err16));

  // Register-file models: data is only valid exactly RD_LATENCY cycles after rdstb.
  logic [7:0] mem8 [256];
  logic [7:0] p8d;
  logic       p8v;
  logic [7:0] q16d [2];
  logic       q16v [2];

  always @(posedge clk) begin
    p8d     <= mem8[oaddr8];
    p8v     <= rd8;
    q16d[0] <= oaddr16[7:0];
    q16v[0] <= rd16;
    q16d[1] <= q16d[0];
    q16v[1] <= q16v[0];
  end
  assign idata8  = p8v ? p8d : ~p8d;
  assign idata16 = q16v[1] ? q16d[1] : ~q16d[1];

  logic        sel = 1'b0;
  logic        o_sdo, o_en, o_rd, o_wr, o_pm, o_pu, o_busy, o_err;
  logic [7:0]  o_odata;
  logic [15:0] o_addr;

  always_comb begin
    o_sdo   = sel ? sdo16   : sdo8;
    o_en    = sel ? en16    : en8;
    o_rd    = sel ? rd16    : rd8;
    o_wr    = sel ? wr16    : wr8;
    o_pm    = sel ? pm16    : pm8;
    o_pu    = sel ? pu16    : pu8;
    o_busy  = sel ? busy16  : busy8;
    o_err   = sel ? err16   : err8;
    o_odata = sel ? odata16 : odata8;
    o_addr  = sel ? oaddr16 : {8'h00, oaddr8};
  end

  int   errors = 0;
  int   checks = 0;
  int   errp = 0;
  int   both = 0;
  ev_t  evq[$];

  always @(negedge clk) begin
    if (o_wr) evq.push_back({1'b1, o_addr, o_odata});
    if (o_rd) evq.push_back({1'b0, o_addr, 8'h00});
    if (o_err) errp++;
    if ((rd8 && wr8) || (rd16 && wr16)) both++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_csb(input logic v);
    if (sel) csb16 = v;
    else csb8 = v;
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic e);
    sdi = b;
    clks(H);
    r = o_sdo;
    e = o_en;
    sck = 1'b1;
    clks(H);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic e0);
    logic r, e;
    rx = '0;
    e0 = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, e);
      rx[i] = r;
      if (i == 7) e0 = e;
    end
  endtask

  task automatic start_txn();
    set_csb(1'b0);
    clks(H);
    evq.delete();
    errp = 0;
  endtask

  task automatic stop_txn();
    clks(H);
    set_csb(1'b1);
    clks(3 * H);
  endtask

  function automatic logic [7:0] rd_value(input logic s, input logic [15:0] a);
    return s ? a[7:0] : mem8[a[7:0]];
  endfunction

  // Expected strobe sequence from the command rules: optional first read at A, then per
  // data byte a write to A+i and, if the transfer continues, a read of A+i+1.
  task automatic run_txn(input logic s, input logic [7:0] cmd, input logic [15:0] addr_in,
                         input int k, input logic [7:0] d [8], input logic [7:0] tail,
                         input bit tail_en, input string nm);
    ev_t         expq[$];
    logic [15:0] mask, addr, a;
    logic [7:0]  rx, expv;
    logic        e0, w, r;
    int          n, ab;
    sel  = s;
    mask = s ? 16'hFFFF : 16'h00FF;
    ab   = s ? 2 : 1;
    addr = addr_in & mask;
    w    = cmd[7];
    r    = cmd[6];
    n    = int'(cmd[5:3]);
    if (r) expq.push_back({1'b0, addr, 8'h00});
    for (int i = 0; i < k; i++) begin
      a = (addr + 16'(i)) & mask;
      if (w) expq.push_back({1'b1, a, d[i]});
      if (r && (n == 0 || i + 1 < n)) expq.push_back({1'b0, (a + 16'd1) & mask, 8'h00});
    end

    start_txn();
    spi_byte(cmd, rx, e0);
    for (int b = ab - 1; b >= 0; b--) spi_byte(addr[8*b +: 8], rx, e0);
    for (int i = 0; i < k; i++) begin
      spi_byte(d[i], rx, e0);
      a = (addr + 16'(i)) & mask;
      if (r) begin
        expv = rd_value(s, a);
        checks++;
        if (rx !== expv) begin
          errors++;
          $display("FAIL %s sdo_byte%0d: got %h expected %h", nm, i, rx, expv);
        end
      end
      checks++;
      if (e0 !== ~r) begin
        errors++;
        $display("FAIL %s sdoenb_byte%0d: got %b expected %b", nm, i, e0, ~r);
      end
    end
    if (tail_en) begin
      spi_byte(tail, rx, e0);
      clks(4);
      checks++;
      if ({o_pm, o_pu, o_en} !== 3'b010) begin
        errors++;
        $display("FAIL %s tail_as_command: pm/pu/sdoenb got %b expected 010", nm, {o_pm, o_pu, o_en});
      end
    end
    stop_txn();

    checks++;
    if (evq.size() != expq.size()) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d expected %0d", nm, evq.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (evq[i] !== expq[i]) begin
          errors++;
          $display("FAIL %s strobe%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h", nm, i,
                   evq[i].wr, evq[i].a, evq[i].d, expq[i].wr, expq[i].a, expq[i].d);
        end
      end
    end
    checks++;
    if (errp != 0) begin
      errors++;
      $display("FAIL %s xfer_err: got %0d pulses expected 0", nm, errp);
    end
    checks++;
    if ({o_busy, o_en, o_pm, o_pu} !== 4'b0100) begin
      errors++;
      $display("FAIL %s idle: busy/sdoenb/pm/pu got %b expected 0100", nm, {o_busy, o_en, o_pm, o_pu});
    end
  endtask

  logic [7:0] dat [8];

  task automatic test_reset();
    rst_n = 1'b0;
    clks(4);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_sdo, o_en, o_odata, o_addr, o_rd, o_wr, o_pm, o_pu, o_busy, o_err} !== 32'h4000_0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 40000000", s,
                 {o_sdo, o_en, o_odata, o_addr, o_rd, o_wr, o_pm, o_pu, o_busy, o_err});
      end
    end
    rst_n = 1'b1;
    clks(6);
  endtask

  task automatic test_write_single();
    dat[0] = 8'hA5;
    run_txn(1'b0, 8'h88, 16'h0012, 1, dat, 8'h00, 1'b0, "write_single");
    dat[0] = 8'($urandom);
    run_txn(1'b0, 8'h88, 16'($urandom), 1, dat, 8'h00, 1'b0, "write_single_rnd");
  endtask

  task automatic test_stream_read();
    run_txn(1'b1, 8'h40, 16'hFFFF, 3, dat, 8'h00, 1'b0, "stream_read_wrap");
  endtask

  task automatic test_rw_count();
    dat[0] = 8'h11;
    dat[1] = 8'h22;
    run_txn(1'b0, 8'hD0, 16'h0008, 2, dat, 8'h82, 1'b1, "rw_count2");
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic       e0, r, e;
    sel = 1'b0;
    start_txn();
    spi_byte(8'h80, rx, e0);
    spi_byte(8'($urandom), rx, e0);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom), r, e);
    stop_txn();
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL abort_data strobes: got %0d expected 0", evq.size());
    end
    checks++;
    if (errp != 1) begin
      errors++;
      $display("FAIL abort_data xfer_err: got %0d pulses expected 1", errp);
    end
    checks++;
    if ({o_busy, o_en} !== 2'b01) begin
      errors++;
      $display("FAIL abort_data idle: busy/sdoenb got %b expected 01", {o_busy, o_en});
    end
    sel = 1'b1;
    start_txn();
    spi_byte(8'h40, rx, e0);
    spi_byte(8'($urandom), rx, e0);
    stop_txn();
    checks++;
    if (evq.size() != 0 || errp != 1) begin
      errors++;
      $display("FAIL abort_addr: got %0d strobes %0d err pulses expected 0 and 1", evq.size(), errp);
    end
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    run_txn(1'b0, 8'hC0, 16'($urandom), 3, dat, 8'h00, 1'b0, "after_abort8");
    run_txn(1'b1, 8'h58, 16'($urandom), 3, dat, 8'h00, 1'b0, "after_abort16");
  endtask

  task automatic test_passthru();
    logic [7:0] rx, cmd;
    logic       e0;
    logic [2:0] expv;
    sel = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cmd  = (j == 0) ? 8'hC4 : 8'hC2;
      expv = (j == 0) ? 3'b100 : 3'b010;
      start_txn();
      spi_byte(cmd, rx, e0);
      clks(4);
      checks++;
      if ({o_pm, o_pu, o_en} !== expv) begin
        errors++;
        $display("FAIL passthru_%h enter: pm/pu/sdoenb got %b expected %b", cmd, {o_pm, o_pu, o_en}, expv);
      end
      spi_byte(8'($urandom), rx, e0);
      spi_byte(8'($urandom), rx, e0);
      checks++;
      if ({o_pm, o_pu, o_en} !== expv || evq.size() != 0) begin
        errors++;
        $display("FAIL passthru_%h hold: pm/pu/sdoenb got %b strobes %0d expected %b and 0",
                 cmd, {o_pm, o_pu, o_en}, evq.size(), expv);
      end
      stop_txn();
      checks++;
      if ({o_pm, o_pu, o_en, o_busy} !== 4'b0010 || errp != 0) begin
        errors++;
        $display("FAIL passthru_%h exit: pm/pu/sdoenb/busy got %b err %0d expected 0010 and 0",
                 cmd, {o_pm, o_pu, o_en, o_busy}, errp);
      end
    end
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    run_txn(1'b1, 8'hC4, 16'($urandom), 2, dat, 8'h00, 1'b0, "passthru_disabled");
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic       e0, r, e;
    sel = 1'b0;
    start_txn();
    spi_byte(8'hC0, rx, e0);
    spi_byte(8'h3C, rx, e0);
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom), r, e);
    clks(1);
    rst_n = 1'b0;
    clks(1);
    checks++;
    if ({o_sdo, o_en, o_odata, o_addr, o_rd, o_wr, o_pm, o_pu, o_busy, o_err} !== 32'h4000_0000) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h expected 40000000",
               {o_sdo, o_en, o_odata, o_addr, o_rd, o_wr, o_pm, o_pu, o_busy, o_err});
    end
    rst_n = 1'b1;
    clks(2 * H);
    set_csb(1'b1);
    clks(3 * H);
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    run_txn(1'b0, 8'hC8, 16'($urandom), 1, dat, 8'h00, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int         k;
    for (int it = 0; it < 14; it++) begin
      cmd = {2'($urandom), 3'($urandom), 3'b000};
      k   = (cmd[5:3] != 3'd0) ? int'(cmd[5:3]) : 1 + int'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      run_txn(1'($urandom), cmd, 16'($urandom), k, dat, 8'h00, 1'b0, $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    sdi   = 1'b0;
    csb8  = 1'b1;
    csb16 = 1'b1;
    for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) dat[i] = 8'h00;
    test_reset();
    test_write_single();
    test_stream_read();
    test_rw_count();
    test_abort();
    test_passthru();
    test_reset_mid();
    test_random();
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: rdstb&wrstb together in %0d cycles expected 0", both);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
